// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: FSM state encoding,
// the read pattern returned on a range error, and the wait counter width.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          LAT_CNT_W          = 4;
    localparam logic [31:0] ERROR_READ_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word-addressed storage for the memory bus responder.
// Synchronous write; registered read that holds its value between reads.
module mem_resp_array #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write port.
    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation instead of RAM, and its contents must survive reset.
    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port; keeps the last read word until the next read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU multicycle bus: accepts a request,
// inserts READ_LATENCY / WRITE_LATENCY wait states, then pulses ack for
// one cycle with read data.
// Optional macro MEM_BUS_RESPONDER_RANGE_CHECK_EN: requests with
// address >= NUM_WORDS skip the array and complete with error = 1
// (reads return ERROR_READ_PATTERN). Without it addresses wrap and
// error is tied low.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 13,
    parameter int DATA_BUS_WIDTH    = 32,
    parameter int NUM_WORDS         = 8192,
    parameter int READ_LATENCY      = 2,
    parameter int WRITE_LATENCY     = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         read_not_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0] address,
    input  logic [DATA_BUS_WIDTH-1:0]    write_data,
    output logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic                         ack,
    output logic                         busy,
    output logic                         error
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    // Counter load values: the counter expires on the edge LATENCY
    // cycles after the accept edge.
    localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] WR_LOAD = LAT_CNT_W'(WRITE_LATENCY - 1);

    state_t                   state;
    state_t                   state_next;
    logic                     accept;
    logic                     commit;
    logic                     range_err;

    logic [IDX_W-1:0]          addr_q;
    logic                      rnw_q;
    logic [DATA_BUS_WIDTH-1:0] wdata_q;
    logic [LAT_CNT_W-1:0]      cnt_q;
    logic                      err_q;

    logic                      mem_en;
    logic [DATA_BUS_WIDTH-1:0] mem_rdata;

`ifdef MEM_BUS_RESPONDER_RANGE_CHECK_EN
    localparam logic [ADDRESS_BUS_WIDTH:0] NUM_WORDS_EXT =
        (ADDRESS_BUS_WIDTH + 1)'(NUM_WORDS);
    logic pat_sel_q;

    assign range_err = ({1'b0, address} >= NUM_WORDS_EXT);
`else
    assign range_err = 1'b0;
`endif

    // Next-state and handshake decode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture and wait-state counter; bus inputs are only
    // sampled on the accept edge, so mid-access changes have no effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= address[IDX_W-1:0];
            rnw_q   <= read_not_write;
            wdata_q <= write_data;
            cnt_q   <= read_not_write ? RD_LOAD : WR_LOAD;
            err_q   <= range_err;
        end else if (state == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The array is touched only on the commit edge of an in-range access.
    assign mem_en = commit && !err_q;

    mem_resp_array #(
        .ADDR_W (IDX_W),
        .DATA_W (DATA_BUS_WIDTH),
        .DEPTH  (NUM_WORDS)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .en    (mem_en),
        .we    (!rnw_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

`ifdef MEM_BUS_RESPONDER_RANGE_CHECK_EN
    // Remember whether the most recent read was out of range, so the
    // error pattern is held just like real read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_sel_q <= 1'b0;
        end else if (commit && rnw_q) begin
            pat_sel_q <= err_q;
        end
    end

    assign read_data = pat_sel_q ? DATA_BUS_WIDTH'(ERROR_READ_PATTERN) : mem_rdata;
    assign error     = (state == RESP) && err_q;
`else
    assign read_data = mem_rdata;
    assign error     = 1'b0;
`endif

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's multicycle memory bus.
- Accepts read/write requests issued by the control FSM, inserts a parameterised number of wait states, then returns a one-cycle ack with read data.
- Replaces the zero-wait combinational RAM model, so the control FSM can be exercised against realistic memory latency.
- Sits between the CPU top (address mux, tri-state write path) and the word-addressed storage array.

Parameters:
- ADDRESS_BUS_WIDTH, 13, word address width.
- DATA_BUS_WIDTH, 32, data word width.
- NUM_WORDS, 8192, storage depth; power of two, at most 2**ADDRESS_BUS_WIDTH.
- READ_LATENCY, 2, cycles from accept to ack for reads; 1 to 15.
- WRITE_LATENCY, 1, cycles from accept to ack for writes; 1 to 15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  request valid; held by the initiator until ack.
- read_not_write  in  1  1 = read, 0 = write; valid with req.
- address  in  ADDRESS_BUS_WIDTH  word address; valid with req.
- write_data  in  DATA_BUS_WIDTH  store data; valid with req when read_not_write = 0.
- read_data  out  DATA_BUS_WIDTH  load data; valid while ack = 1, then held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from accept until ack inclusive.
- error  out  1  range-error flag, qualified by ack; constant 0 when the optional feature is compiled out.

Behaviour:
- State machine has three states: IDLE, WAIT, RESP.
- Reset (reset = 0, asynchronous):
  - state = IDLE; ack = 0; busy = 0; error = 0; read_data = 0; wait counter = 0.
  - Array contents are not cleared.
- IDLE:
  - At a rising edge T0 with req = 1: latch address, read_not_write and write_data; load the counter with the selected latency minus 1; go to WAIT; busy = 1 from T0.
  - With req = 0: stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, go to RESP.
  - On that same edge, a write commits the latched data to the array, or a read captures array data into read_data.
- RESP:
  - ack = 1 and busy = 1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: ack is high in the cycle following edge T0 + LATENCY (read or write latency as selected).
- Throughput: at most one access per LATENCY + 2 cycles. While ack = 1, req is ignored. If req is still high in IDLE it is accepted as a new request, so an initiator that fails to drop req gets a repeat access; verification flags this.
- Bus inputs are ignored while busy, because the latched copies are used. Changes to address or data mid-access have no effect.
- A write to address A followed by a read of A returns the new data: the array write completes before any later read capture.
- Reset mid-access:
  - A write is discarded unless its commit edge has already occurred.
  - No ack is produced for the aborted request.
- Address indexing: array index = address modulo NUM_WORDS, using the low log2(NUM_WORDS) bits.

Optional Feature:
- Macro: MEM_BUS_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - A request with address >= NUM_WORDS performs no array access.
  - It completes with normal timing, with ack = 1 and error = 1.
  - For a read, read_data = 32'hDEAD_BEEF.
  - Writes to out-of-range addresses are dropped.
- Undefined: address wraps modulo NUM_WORDS; error is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the error read pattern constant;
  - the latency counter width (4).
- Address and data width defaults stay in the common CPU parameter set.
- One sub-module is natural: mem_resp_array. It is a single-port storage array with synchronous write and registered read, enabled by the responder FSM.

Test Plan:
- Reset: drive reset = 0 mid-run -> ack = 0, busy = 0, error = 0, read_data = 0 immediately, without waiting for a clock edge.
- Write then read: write 32'h1234_5678 to address 13'd4096 with READ_LATENCY = 2 and WRITE_LATENCY = 1 -> write ack at T0 + 1. Then read 4096 -> ack one cycle after edge T0 + 2, read_data = 32'h1234_5678, held after ack.
- Back-to-back: req held through ack for reads of 0 and 1 -> second accept on the first IDLE edge after RESP, spacing 4 cycles, no lost or duplicated acks.
- Input stability: change address and write_data during WAIT -> the originally latched address and data are stored.
- Reset mid-write: assert reset during WAIT of a write to address 5 -> no ack; a subsequent read of 5 returns the prior contents.
- Range check (macro defined, NUM_WORDS = 4096): read address 5000 -> ack = 1, error = 1, read_data = 32'hDEAD_BEEF. Write to address 5000, then read address 904 (5000 mod 4096) -> the value at 904 is unchanged.
